// File: rtl/seq_slice_adder.sv
// Multi-cycle wide adder: streams NSLICE 8-bit slices through one carry-select
// core, LSB first, with a registered inter-slice carry and valid/ready on both sides.

module csa8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    // Upper nibble is precomputed for both possible carries and selected by the lower carry
    always_comb begin
        lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(cin);
        hi0  = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi1  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
        sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
        cout = lo[4] ? hi1[4] : hi0[4];
    end
endmodule

module seq_slice_adder #(
    parameter int unsigned NSLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NSLICE-1:0]   in_a,
    input  logic [8*NSLICE-1:0]   in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NSLICE-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_ovf
);
    localparam int unsigned W  = 8 * NSLICE;
    localparam int unsigned IW = $clog2(NSLICE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   op_a, op_a_nxt;
    logic [W-1:0]   op_b, op_b_nxt;
    logic           carry, carry_nxt;
    logic [IW-1:0]  idx, idx_nxt;
    logic [W-1:0]   sum_r, sum_nxt;
    logic           cout_r, cout_nxt;
    logic           ovf_r, ovf_nxt;

    logic [IW+2:0]  sh;
    logic [7:0]     core_a;
    logic [7:0]     core_b;
    logic [7:0]     core_sum;
    logic           core_cout;
    logic           idx_last;
    logic           idx_bad;

    assign sh       = {idx, 3'b000};
    assign core_a   = 8'(op_a >> sh);
    assign core_b   = 8'(op_b >> sh);
    assign idx_last = (idx == IW'(NSLICE - 1));
    assign idx_bad  = ({1'b0, idx} >= (IW+1)'(NSLICE));

    csa8 u_core (
        .a    (core_a),
        .b    (core_b),
        .cin  (carry),
        .sum  (core_sum),
        .cout (core_cout)
    );

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        op_a_nxt  = op_a;
        op_b_nxt  = op_b;
        carry_nxt = carry;
        idx_nxt   = idx;
        sum_nxt   = sum_r;
        cout_nxt  = cout_r;
        ovf_nxt   = ovf_r;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    op_a_nxt  = in_a;
                    op_b_nxt  = in_b;
                    carry_nxt = in_cin;
                    idx_nxt   = '0;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (idx_bad) begin
                    state_nxt = S_IDLE;
                end else begin
                    sum_nxt   = (sum_r & ~(W'(8'hFF) << sh)) | (W'(core_sum) << sh);
                    carry_nxt = core_cout;
                    idx_nxt   = idx + IW'(1);
                    if (idx_last) begin
                        cout_nxt  = core_cout;
                        // carry into the MSB is recovered from the MSB sum bit
                        ovf_nxt   = core_cout ^ (op_a[W-1] ^ op_b[W-1] ^ core_sum[7]);
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum_r     <= '0;
            cout_r    <= 1'b0;
            ovf_r     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            op_a      <= op_a_nxt;
            op_b      <= op_b_nxt;
            carry     <= carry_nxt;
            idx       <= idx_nxt;
            sum_r     <= sum_nxt;
            cout_r    <= cout_nxt;
            ovf_r     <= ovf_nxt;
            in_ready  <= (state_nxt == S_IDLE);
            out_valid <= (state_nxt == S_DONE);
        end
    end

    assign out_sum  = sum_r;
    assign out_cout = cout_r;
    assign out_ovf  = ovf_r;
endmodule

// File: tb/tb_seq_slice_adder.sv
// Directed and reference-checked bench for seq_slice_adder at NSLICE=4 and NSLICE=2.

module tb_seq_slice_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_valid4, in_valid2;
    logic        out_ready4, out_ready2;
    logic        in_ready4, in_ready2;
    logic        out_valid4, out_valid2;
    logic [31:0] out_sum4;
    logic [15:0] out_sum2;
    logic        out_cout4, out_cout2;
    logic        out_ovf4, out_ovf2;
    bit          sel;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    seq_slice_adder #(.NSLICE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_sum(out_sum4), .out_cout(out_cout4), .out_ovf(out_ovf4)
    );

    seq_slice_adder #(.NSLICE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_sum(out_sum2), .out_cout(out_cout2), .out_ovf(out_ovf2)
    );

    wire        cur_in_ready  = sel ? in_ready2  : in_ready4;
    wire        cur_out_valid = sel ? out_valid2 : out_valid4;
    wire [31:0] cur_sum       = sel ? {16'h0, out_sum2} : out_sum4;
    wire        cur_cout      = sel ? out_cout2 : out_cout4;
    wire        cur_ovf       = sel ? out_ovf2  : out_ovf4;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input bit v);
        if (sel) in_valid2 = v; else in_valid4 = v;
    endtask

    task automatic set_ready(input bit r);
        if (sel) out_ready2 = r; else out_ready4 = r;
    endtask

    // One full transaction: accept, optional input scrambling during RUN, hold, handshake
    task automatic run_op(input bit d2, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] esum, input logic ecout,
                          input logic eovf, input int hold, input bit scramble,
                          input string tag);
        int n;
        sel = d2;
        #0;
        in_a = a; in_b = b; in_cin = cin;
        set_valid(1'b1);
        n = 0;
        while (!cur_in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk({tag, "_ready_timeout"}, 64'(n), 64'd0);
        step();
        set_valid(1'b0);
        n = 0;
        while (!cur_out_valid && n < 50) begin
            if (scramble) begin
                in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
            end
            step();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), d2 ? 64'd2 : 64'd4);
        chk({tag, "_sum"}, 64'(cur_sum), 64'(esum));
        chk({tag, "_cout"}, 64'(cur_cout), 64'(ecout));
        chk({tag, "_ovf"}, 64'(cur_ovf), 64'(eovf));
        for (int h = 0; h < hold; h++) begin
            set_ready(1'b0);
            step();
            chk({tag, "_hold_valid"}, 64'(cur_out_valid), 64'd1);
            chk({tag, "_hold_sum"}, 64'(cur_sum), 64'(esum));
            chk({tag, "_hold_cout"}, 64'(cur_cout), 64'(ecout));
            chk({tag, "_hold_ovf"}, 64'(cur_ovf), 64'(eovf));
            chk({tag, "_hold_inrdy"}, 64'(cur_in_ready), 64'd0);
        end
        set_ready(1'b1);
        step();
        set_ready(1'b0);
        chk({tag, "_valid_drop"}, 64'(cur_out_valid), 64'd0);
        chk({tag, "_inrdy_rise"}, 64'(cur_in_ready), 64'd1);
    endtask

    task automatic rand_op(input bit d2, input int idx);
        logic [31:0] a, b, s;
        logic        c, co, ov;
        logic [32:0] r;
        int          msb;
        msb = d2 ? 15 : 31;
        a = $urandom; b = $urandom; c = 1'($urandom);
        if (d2) begin
            a = a & 32'h0000FFFF;
            b = b & 32'h0000FFFF;
        end
        r  = {1'b0, a} + {1'b0, b} + 33'(c);
        s  = d2 ? (r[31:0] & 32'h0000FFFF) : r[31:0];
        co = r[msb+1];
        ov = (a[msb] == b[msb]) && (s[msb] != a[msb]);
        run_op(d2, a, b, c, s, co, ov, $urandom_range(0, 3), 1'b0,
               $sformatf("rand%0d_%0d", d2 ? 2 : 4, idx));
    endtask

    initial begin
        rst = 1'b1;
        in_a = '0; in_b = '0; in_cin = 1'b0;
        in_valid4 = 1'b0; in_valid2 = 1'b0;
        out_ready4 = 1'b0; out_ready2 = 1'b0;
        sel = 1'b0;
        step();
        step();
        chk("rst_in_ready", 64'(in_ready4), 64'd1);
        chk("rst_out_valid", 64'(out_valid4), 64'd0);
        chk("rst_sum", 64'(out_sum4), 64'd0);
        chk("rst_cout", 64'(out_cout4), 64'd0);
        chk("rst_ovf", 64'(out_ovf4), 64'd0);
        rst = 1'b0;
        step();

        run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 0, 1'b0, "wrap");
        run_op(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 0, 1'b0, "posovf");
        run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 0, 1'b0, "negovf");
        run_op(1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0, 0, 1'b1, "scramble");
        run_op(1'b0, 32'h00010001, 32'h0000FFFF, 1'b1, 32'h00020001, 1'b0, 1'b0, 5, 1'b0, "backpress");

        // Reset in the second RUN cycle discards the operation
        sel = 1'b0;
        in_a = 32'hDEADBEEF; in_b = 32'h11111111; in_cin = 1'b1;
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("abort_valid", 64'(out_valid4), 64'd0);
        chk("abort_sum", 64'(out_sum4), 64'd0);
        chk("abort_cout", 64'(out_cout4), 64'd0);
        chk("abort_in_ready", 64'(in_ready4), 64'd1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_valid", 64'(out_valid4), 64'd0);
        end
        run_op(1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 0, 1'b0, "post_abort");

        run_op(1'b1, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 0, 1'b0, "n2_wrap");
        run_op(1'b1, 32'h00007FFF, 32'h00000001, 1'b0, 32'h00008000, 1'b0, 1'b1, 0, 1'b0, "n2_ovf");

        for (int i = 0; i < 1000; i++) rand_op(1'b0, i);
        for (int i = 0; i < 1000; i++) rand_op(1'b1, i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
